// File: rtl/pc_gen_if.sv
// Fetch-side bundle for pc_gen: redirect channels, pipeline controls and the
// fetch handshake, together with the status outputs.
interface pc_gen_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int NUM_REDIRECT = 3,
    parameter int CNT_WIDTH    = 16
);
    logic [NUM_REDIRECT-1:0]            redirect_valid_i;
    logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_target_i;
    logic                               stall_i;
    logic                               halt_i;
    logic                               fetch_ready_i;
    logic                               fetch_valid_o;
    logic [ADDR_WIDTH-1:0]              fetch_pc_o;
    logic                               redirect_taken_o;
    logic                               misalign_o;
    logic [ADDR_WIDTH-1:0]              misalign_addr_o;
    logic [CNT_WIDTH-1:0]               redirect_cnt_o;
    logic                               halted_o;

    // Pipeline / fetch-unit side
    modport master (
        output redirect_valid_i, redirect_target_i, stall_i, halt_i, fetch_ready_i,
        input  fetch_valid_o, fetch_pc_o, redirect_taken_o, misalign_o,
               misalign_addr_o, redirect_cnt_o, halted_o
    );

    // PC generator side
    modport slave (
        input  redirect_valid_i, redirect_target_i, stall_i, halt_i, fetch_ready_i,
        output fetch_valid_o, fetch_pc_o, redirect_taken_o, misalign_o,
               misalign_addr_o, redirect_cnt_o, halted_o
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: boots at PC_ADDR, advances by 4 per
// accepted fetch, takes the highest-priority redirect (channel 0 first),
// and supports halt/resume, misaligned-target reporting and a saturating
// redirect counter.
module pc_gen #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] PC_ADDR      = 32'h8000_0000,
    parameter int                    NUM_REDIRECT = 3,
    parameter int                    CNT_WIDTH    = 16
) (
    input logic     clk_i,
    input logic     rst_i,
    pc_gen_if.slave bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  taken_q;
    logic                  mis_q;
    logic [ADDR_WIDTH-1:0] mis_addr_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic                  win_vld;
    logic [ADDR_WIDTH-1:0] win_tgt;
    logic                  apply;
    logic                  fire;

    // Priority pick: scan high to low so the lowest asserted index wins
    always_comb begin
        win_vld = |bus.redirect_valid_i;
        win_tgt = '0;
        for (int k = NUM_REDIRECT - 1; k >= 0; k--) begin
            if (bus.redirect_valid_i[k])
                win_tgt = bus.redirect_target_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Redirects are dead during the BOOT cycle; otherwise they win over
    // stall, halt and the handshake alike.
    assign apply = win_vld && (state != BOOT);
    assign fire  = bus.fetch_valid_o && bus.fetch_ready_i;

    assign bus.fetch_valid_o    = (state == RUN) && !bus.stall_i;
    assign bus.fetch_pc_o       = pc_q;
    assign bus.redirect_taken_o = taken_q;
    assign bus.misalign_o       = mis_q;
    assign bus.misalign_addr_o  = mis_addr_q;
    assign bus.redirect_cnt_o   = cnt_q;
    assign bus.halted_o         = (state == HALT);

    // Control FSM: one dead boot cycle, then run; halt only when no redirect
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= BOOT;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (bus.halt_i && !win_vld) state <= HALT;
                HALT:    if (win_vld) state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    // PC update: aligned redirect target, else +4 on handshake, else hold
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            pc_q <= PC_ADDR;
        else if (apply)
            pc_q <= {win_tgt[ADDR_WIDTH-1:2], 2'b00};
        else if (fire)
            pc_q <= pc_q + ADDR_WIDTH'(4);
    end

    // Redirect status: one-cycle pulses, sticky misalign address, saturating count
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            taken_q    <= 1'b0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
            cnt_q      <= '0;
        end else begin
            taken_q <= apply;
            mis_q   <= apply && (win_tgt[1:0] != 2'b00);
            if (apply && (win_tgt[1:0] != 2'b00))
                mis_addr_q <= win_tgt;
            if (apply && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end
endmodule
